// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder, instruction fetch handshake and next-PC selection
// One instruction in flight: IDLE -> FETCH (wait for ready) -> EXEC (hold while stalled) -> FETCH.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [5:0]  BEQ_OPCODE = 6'h04,
  parameter logic [5:0]  BNE_OPCODE = 6'h05
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [5:0]  o_op,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  input  logic        i_jump,
  input  logic        i_branch,
  input  logic        i_alu_zero,
  input  logic        i_stall,
  output logic [31:0] o_retired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;
  logic [31:0] r_retired;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_off;
  logic [31:0] w_next_pc;
  logic [5:0]  w_op;
  logic        w_taken;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_op         = r_instr[31:26];
  assign w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  // Branch is shared between BEQ and BNE; any other opcode with branch=1 falls through.
  always_comb begin
    w_taken   = 1'b0;
    w_next_pc = w_pc_plus4;
    if ((w_op == BEQ_OPCODE) && i_alu_zero)
      w_taken = 1'b1;
    if ((w_op == BNE_OPCODE) && !i_alu_zero)
      w_taken = 1'b1;
    if (i_jump)
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    else if (i_branch && w_taken)
      w_next_pc = w_pc_plus4 + w_branch_off;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_retired <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (i_imem_ready) begin
            r_instr <= i_imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!i_stall) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + 32'd1;
            r_valid   <= 1'b0;
            r_req     <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req      = r_req;
  assign o_imem_addr     = r_pc;
  assign o_instr         = r_instr;
  assign o_op            = w_op;
  assign o_instr_valid   = r_valid;
  assign o_pc            = r_pc;
  assign o_pc_plus4      = w_pc_plus4;
  assign o_retired_count = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed plus randomized checks of instr_fetch_unit against a PC model
module tb_instr_fetch_unit;

  logic        clk;
  int          n_tests;
  int          n_fail;

  logic        rst_n, ready, jump, branch, zero, stall;
  logic [31:0] rdata;
  logic        req, valid;
  logic [31:0] addr, instr, pc, pc4, cnt;
  logic [5:0]  op;

  logic        rst2_n, ready2;
  logic [31:0] rdata2;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, pc42, cnt2;
  logic [5:0]  op2;

  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  instr_fetch_unit dut (
    .i_clk(clk), .i_reset(rst_n), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ready(ready), .i_imem_rdata(rdata), .o_instr(instr), .o_op(op),
    .o_instr_valid(valid), .o_pc(pc), .o_pc_plus4(pc4), .i_jump(jump),
    .i_branch(branch), .i_alu_zero(zero), .i_stall(stall), .o_retired_count(cnt)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .i_clk(clk), .i_reset(rst2_n), .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_ready(ready2), .i_imem_rdata(rdata2), .o_instr(instr2), .o_op(op2),
    .o_instr_valid(valid2), .o_pc(pc2), .o_pc_plus4(pc42), .i_jump(1'b0),
    .i_branch(1'b0), .i_alu_zero(1'b0), .i_stall(1'b0), .o_retired_count(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC straight from the ISA rules.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                           input logic j, input logic b, input logic z);
    logic [31:0] p4;
    int          off;
    int          opc;
    p4  = cur + 32'd4;
    opc = int'(w[31:26]);
    off = int'($signed(w[15:0]));
    if (j)
      return {p4[31:28], 28'(w[25:0]) * 28'd4};
    if (b && ((opc == 4 && z) || (opc == 5 && !z)))
      return p4 + 32'(off * 4);
    return p4;
  endfunction

  // Entered with the DUT in FETCH just after an edge; leaves it in the following FETCH.
  task automatic run_instr(input logic [31:0] w, input int waits, input logic j,
                           input logic b, input logic z, input int stalls);
    chk("fetch_req", {31'd0, req}, 32'd1);
    chk("fetch_addr", addr, exp_pc);
    chk("fetch_valid", {31'd0, valid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      ready  = 1'b0;
      rdata  = $urandom;
      jump   = 1'($urandom);
      branch = 1'($urandom);
      zero   = 1'($urandom);
      stall  = 1'($urandom);
      step();
      chk("wait_req", {31'd0, req}, 32'd1);
      chk("wait_addr", addr, exp_pc);
      chk("wait_valid", {31'd0, valid}, 32'd0);
    end
    ready = 1'b1;
    rdata = w;
    step();
    ready  = 1'($urandom);
    rdata  = $urandom;
    jump   = j;
    branch = b;
    zero   = z;
    stall  = (stalls > 0);
    chk("exec_valid", {31'd0, valid}, 32'd1);
    chk("exec_req", {31'd0, req}, 32'd0);
    chk("exec_instr", instr, w);
    chk("exec_op", {26'd0, op}, {26'd0, w[31:26]});
    chk("exec_pc", pc, exp_pc);
    chk("exec_pc4", pc4, exp_pc + 32'd4);
    for (int i = 0; i < stalls; i++) begin
      step();
      stall = (i + 1 < stalls);
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_pc", pc, exp_pc);
      chk("stall_cnt", cnt, exp_cnt);
    end
    step();
    exp_pc  = ref_next(exp_pc, w, j, b, z);
    exp_cnt = exp_cnt + 32'd1;
    stall   = 1'b0;
    ready   = 1'b0;
    chk("next_addr", addr, exp_pc);
    chk("next_cnt", cnt, exp_cnt);
    chk("next_valid", {31'd0, valid}, 32'd0);
    chk("next_req", {31'd0, req}, 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    logic        rj, rb;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; ready = 1'b0; rdata = 32'd0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; stall = 1'b0;
    rst2_n = 1'b0; ready2 = 1'b0; rdata2 = 32'd0;
    exp_pc  = 32'h0040_0000;
    exp_cnt = 32'd0;
    repeat (2) step();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);

    rst_n = 1'b1;
    step();
    chk("idle_exit_req", {31'd0, req}, 32'd1);

    run_instr(32'h2008_0005, 0, 1'b0, 1'b0, 1'b0, 0);
    run_instr(32'h2009_0007, 3, 1'b0, 1'b0, 1'b0, 0);
    run_instr(32'h0000_0020, 0, 1'b0, 1'b1, 1'b1, 0);
    run_instr(32'h8c0a_0000, 1, 1'b0, 1'b0, 1'b0, 1);
    chk("pc_at_beq", exp_pc, 32'h0040_0010);
    run_instr(32'h1000_FFFF, 0, 1'b0, 1'b1, 1'b1, 0);
    chk("beq_taken", exp_pc, 32'h0040_0010);
    run_instr(32'h1000_FFFF, 0, 1'b0, 1'b1, 1'b0, 0);
    run_instr(32'h1400_FFFF, 0, 1'b0, 1'b1, 1'b0, 0);
    run_instr(32'h1400_FFFF, 0, 1'b0, 1'b1, 1'b1, 0);
    run_instr(32'h0810_0008, 0, 1'b1, 1'b0, 1'b0, 0);
    chk("pc_at_j", exp_pc, 32'h0040_0020);
    run_instr(32'h0810_0008, 0, 1'b1, 1'b1, 1'b1, 2);

    for (int k = 0; k < 24; k++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1)
        w[31:26] = 6'($urandom_range(4, 5));
      rj = ($urandom_range(0, 3) == 0);
      rb = 1'($urandom);
      run_instr(w, $urandom_range(0, 2), rj, rb, 1'($urandom), $urandom_range(0, 2));
    end

    // Abort mid-handshake: reset acts between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req", {31'd0, req}, 32'd0);
    chk("abort_pc", pc, 32'h0040_0000);
    chk("abort_cnt", cnt, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);

    rst2_n = 1'b1;
    step();
    chk("wrap_addr", addr2, 32'hFFFF_FFFC);
    ready2 = 1'b1;
    rdata2 = 32'h0000_0020;
    step();
    ready2 = 1'b0;
    chk("wrap_pc4", pc42, 32'd0);
    chk("wrap_valid", {31'd0, valid2}, 32'd1);
    step();
    chk("wrap_next", addr2, 32'd0);
    chk("wrap_cnt", cnt2, 32'd1);
    step();
    #2;
    rst2_n = 1'b0;
    #1;
    chk("wrap_abort_req", {31'd0, req2}, 32'd0);
    chk("wrap_abort_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_abort_cnt", cnt2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
